// File: rtl/exu_wb_arb.sv
// exu_wb_arb: writeback arbiter merging ALU, LSU and DIV results onto the
// single register-file write port. LSU/DIV results are held in one-entry
// buffers; a starvation monitor asks issue to stall so buffers can drain.
// Optional feature macro: WB_INSTRET_EN (adds 64-bit instret_cnt output).
module exu_wb_arb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   alu_wb_data,
  input  logic [4:0]        alu_wb_rd_addr,
  input  logic              alu_wb_rd_wr_en,
  input  logic              lsu_wb_valid,
  output logic              lsu_wb_ready,
  input  logic [XLEN-1:0]   lsu_wb_data,
  input  logic [4:0]        lsu_wb_rd_addr,
  input  logic              div_wb_valid,
  output logic              div_wb_ready,
  input  logic [XLEN-1:0]   div_wb_data,
  input  logic [4:0]        div_wb_rd_addr,
  output logic              rf_wr_en,
  output logic [4:0]        rf_wr_addr,
  output logic [XLEN-1:0]   rf_wr_data,
`ifdef WB_INSTRET_EN
  output logic [63:0]       instret_cnt,
`endif
  output logic              wb_stall_req
);

  localparam int unsigned AGE_W = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

  // Buffer state and round-robin pointer (0 = LSU next, 1 = DIV next)
  logic              r_lsu_vld;
  logic [4:0]        r_lsu_addr;
  logic [XLEN-1:0]   r_lsu_data;
  logic              r_div_vld;
  logic [4:0]        r_div_addr;
  logic [XLEN-1:0]   r_div_data;
  logic              r_rr_ptr;
  logic [AGE_W-1:0]  r_lsu_age;
  logic [AGE_W-1:0]  r_div_age;

  logic w_alu_req;
  logic w_lsu_grant;
  logic w_div_grant;
  logic w_both_vld;
  logic w_lsu_xfer;
  logic w_div_xfer;
  logic w_lsu_fill;
  logic w_div_fill;

  // Arbitration: ALU first, then the sole valid buffer, else round-robin
  always_comb begin
    w_alu_req   = alu_wb_rd_wr_en & (alu_wb_rd_addr != 5'd0);
    w_both_vld  = r_lsu_vld & r_div_vld;
    w_lsu_grant = ~w_alu_req & r_lsu_vld & (~r_div_vld | ~r_rr_ptr);
    w_div_grant = ~w_alu_req & r_div_vld & (~r_lsu_vld |  r_rr_ptr);
    lsu_wb_ready = ~r_lsu_vld | w_lsu_grant;
    div_wb_ready = ~r_div_vld | w_div_grant;
    w_lsu_xfer  = lsu_wb_valid & lsu_wb_ready;
    w_div_xfer  = div_wb_valid & div_wb_ready;
    w_lsu_fill  = w_lsu_xfer & (lsu_wb_rd_addr != 5'd0);
    w_div_fill  = w_div_xfer & (div_wb_rd_addr != 5'd0);
  end

  // LSU buffer; a fresh entry counts its fill cycle as the first cycle waited
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lsu_vld  <= 1'b0;
      r_lsu_addr <= 5'd0;
      r_lsu_data <= '0;
      r_lsu_age  <= '0;
    end else begin
      if (w_lsu_fill) begin
        r_lsu_vld  <= 1'b1;
        r_lsu_addr <= lsu_wb_rd_addr;
        r_lsu_data <= lsu_wb_data;
        r_lsu_age  <= AGE_W'(1);
      end else if (~r_lsu_vld | w_lsu_grant) begin
        r_lsu_vld  <= 1'b0;
        r_lsu_age  <= '0;
      end else if (r_lsu_age < AGE_MAX) begin
        r_lsu_age  <= r_lsu_age + AGE_W'(1);
      end
    end
  end

  // DIV buffer, mirror of the LSU buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_vld  <= 1'b0;
      r_div_addr <= 5'd0;
      r_div_data <= '0;
      r_div_age  <= '0;
    end else begin
      if (w_div_fill) begin
        r_div_vld  <= 1'b1;
        r_div_addr <= div_wb_rd_addr;
        r_div_data <= div_wb_data;
        r_div_age  <= AGE_W'(1);
      end else if (~r_div_vld | w_div_grant) begin
        r_div_vld  <= 1'b0;
        r_div_age  <= '0;
      end else if (r_div_age < AGE_MAX) begin
        r_div_age  <= r_div_age + AGE_W'(1);
      end
    end
  end

  // Register-file write port, round-robin pointer and stall request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en     <= 1'b0;
      rf_wr_addr   <= 5'd0;
      rf_wr_data   <= '0;
      r_rr_ptr     <= 1'b0;
      wb_stall_req <= 1'b0;
    end else begin
      rf_wr_en <= w_alu_req | w_lsu_grant | w_div_grant;
      if (w_alu_req) begin
        rf_wr_addr <= alu_wb_rd_addr;
        rf_wr_data <= alu_wb_data;
      end else if (w_lsu_grant) begin
        rf_wr_addr <= r_lsu_addr;
        rf_wr_data <= r_lsu_data;
      end else if (w_div_grant) begin
        rf_wr_addr <= r_div_addr;
        rf_wr_data <= r_div_data;
      end
      if (~w_alu_req & w_both_vld) begin
        r_rr_ptr <= ~r_rr_ptr;
      end
      wb_stall_req <= (r_lsu_age >= AGE_MAX) | (r_div_age >= AGE_MAX);
    end
  end

`ifdef WB_INSTRET_EN
  logic [2:0] w_ret_inc;

  // Retired writeback ops this cycle: writes plus x0-discarded results
  always_comb begin
    w_ret_inc = 3'(w_alu_req | w_lsu_grant | w_div_grant)
              + 3'(w_lsu_xfer & (lsu_wb_rd_addr == 5'd0))
              + 3'(w_div_xfer & (div_wb_rd_addr == 5'd0))
              + 3'(alu_wb_rd_wr_en & (alu_wb_rd_addr == 5'd0));
  end

  // Retired-op counter, wraps naturally at 2^64
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_cnt <= 64'd0;
    end else begin
      instret_cnt <= instret_cnt + 64'(w_ret_inc);
    end
  end
`endif

endmodule

// File: tb/tb_exu_wb_arb.sv
// Testbench for exu_wb_arb: directed vector table plus starvation and
// mid-operation reset sequences.
module tb_exu_wb_arb;

  logic        clk;
  logic        rst;
  logic [31:0] alu_wb_data;
  logic [4:0]  alu_wb_rd_addr;
  logic        alu_wb_rd_wr_en;
  logic        lsu_wb_valid;
  logic        lsu_wb_ready;
  logic [31:0] lsu_wb_data;
  logic [4:0]  lsu_wb_rd_addr;
  logic        div_wb_valid;
  logic        div_wb_ready;
  logic [31:0] div_wb_data;
  logic [4:0]  div_wb_rd_addr;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        wb_stall_req;
`ifdef WB_INSTRET_EN
  logic [63:0] instret_cnt;
`endif

  int checks = 0;
  int errors = 0;

  exu_wb_arb #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_wb_data    (alu_wb_data),
    .alu_wb_rd_addr (alu_wb_rd_addr),
    .alu_wb_rd_wr_en(alu_wb_rd_wr_en),
    .lsu_wb_valid   (lsu_wb_valid),
    .lsu_wb_ready   (lsu_wb_ready),
    .lsu_wb_data    (lsu_wb_data),
    .lsu_wb_rd_addr (lsu_wb_rd_addr),
    .div_wb_valid   (div_wb_valid),
    .div_wb_ready   (div_wb_ready),
    .div_wb_data    (div_wb_data),
    .div_wb_rd_addr (div_wb_rd_addr),
    .rf_wr_en       (rf_wr_en),
    .rf_wr_addr     (rf_wr_addr),
    .rf_wr_data     (rf_wr_data),
`ifdef WB_INSTRET_EN
    .instret_cnt    (instret_cnt),
`endif
    .wb_stall_req   (wb_stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_en;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_d;
    logic        div_v;
    logic [4:0]  div_rd;
    logic [31:0] div_d;
    logic        e_lsu_rdy;
    logic        e_div_rdy;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  function automatic vec_t mk(logic ae, logic [4:0] ar, logic [31:0] ad,
                              logic lv, logic [4:0] lr, logic [31:0] ld,
                              logic dv, logic [4:0] dr, logic [31:0] dd,
                              logic elr, logic edr, logic een,
                              logic [4:0] ea, logic [31:0] ed, logic es);
    vec_t v;
    v.alu_en = ae; v.alu_rd = ar; v.alu_d = ad;
    v.lsu_v = lv;  v.lsu_rd = lr; v.lsu_d = ld;
    v.div_v = dv;  v.div_rd = dr; v.div_d = dd;
    v.e_lsu_rdy = elr; v.e_div_rdy = edr; v.e_en = een;
    v.e_addr = ea; v.e_data = ed; v.e_stall = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ae, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic dv, input logic [4:0] dr, input logic [31:0] dd);
    alu_wb_rd_wr_en = ae; alu_wb_rd_addr = ar; alu_wb_data = ad;
    lsu_wb_valid = lv;    lsu_wb_rd_addr = lr; lsu_wb_data = ld;
    div_wb_valid = dv;    div_wb_rd_addr = dr; div_wb_data = dd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic chk_out(input string tag, input logic en, input logic [4:0] a,
                         input logic [31:0] d, input logic st);
    chk({tag, "_en"},    32'(rf_wr_en), 32'(en));
    chk({tag, "_addr"},  32'(rf_wr_addr), 32'(a));
    chk({tag, "_data"},  rf_wr_data, d);
    chk({tag, "_stall"}, 32'(wb_stall_req), 32'(st));
  endtask

  initial begin
    // ALU only, then x0 ALU op
    vt[0]  = mk(1,5,32'h1234, 0,0,0,            0,0,0,            1,1, 1,5,32'h1234, 0);
    vt[1]  = mk(1,0,32'h5555, 0,0,0,            0,0,0,            1,1, 0,5,32'h1234, 0);
    // LSU with ALU idle: 2-cycle latency, then back-to-back
    vt[2]  = mk(0,0,0,        1,7,32'hDEADBEEF, 0,0,0,            1,1, 0,5,32'h1234, 0);
    vt[3]  = mk(0,0,0,        0,0,0,            0,0,0,            1,1, 1,7,32'hDEADBEEF, 0);
    vt[4]  = mk(0,0,0,        1,8,32'h11,       0,0,0,            1,1, 0,7,32'hDEADBEEF, 0);
    vt[5]  = mk(0,0,0,        1,9,32'h22,       0,0,0,            1,1, 1,8,32'h11, 0);
    vt[6]  = mk(0,0,0,        1,10,32'h33,      0,0,0,            1,1, 1,9,32'h22, 0);
    vt[7]  = mk(0,0,0,        0,0,0,            0,0,0,            1,1, 1,10,32'h33, 0);
    vt[8]  = mk(0,0,0,        0,0,0,            0,0,0,            1,1, 0,10,32'h33, 0);
    // Conflict: round-robin LSU, DIV, LSU; ALU preempts
    vt[9]  = mk(0,0,0,        1,1,32'hA1,       1,2,32'hD2,       1,1, 0,10,32'h33, 0);
    vt[10] = mk(0,0,0,        1,3,32'hA3,       1,4,32'hD4,       1,0, 1,1,32'hA1, 0);
    vt[11] = mk(0,0,0,        1,5,32'hA5,       1,4,32'hD4,       0,1, 1,2,32'hD2, 0);
    vt[12] = mk(0,0,0,        1,5,32'hA5,       0,0,0,            1,0, 1,3,32'hA3, 0);
    vt[13] = mk(1,6,32'hCAFE, 0,0,0,            0,0,0,            0,0, 1,6,32'hCAFE, 0);
    vt[14] = mk(0,0,0,        0,0,0,            0,0,0,            0,1, 1,4,32'hD4, 0);
    vt[15] = mk(0,0,0,        0,0,0,            0,0,0,            1,1, 1,5,32'hA5, 0);
    vt[16] = mk(0,0,0,        0,0,0,            0,0,0,            1,1, 0,5,32'hA5, 0);
    // x0 discard on both LSU and DIV
    vt[17] = mk(0,0,0,        1,0,32'hBAD,      1,0,32'hBAD,      1,1, 0,5,32'hA5, 0);
    vt[18] = mk(0,0,0,        0,0,0,            0,0,0,            1,1, 0,5,32'hA5, 0);

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lsu_rdy", 32'(lsu_wb_ready), 32'd1);
    chk("rst_div_rdy", 32'(div_wb_ready), 32'd1);
    chk_out("rst", 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_out("post_rst", 1'b0, 5'd0, 32'd0, 1'b0);
`ifdef WB_INSTRET_EN
    chk("post_rst_instret", instret_cnt[31:0], 32'd0);
`endif

    // Vector table
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].alu_en, vt[i].alu_rd, vt[i].alu_d, vt[i].lsu_v, vt[i].lsu_rd,
            vt[i].lsu_d, vt[i].div_v, vt[i].div_rd, vt[i].div_d);
      #1;
      chk($sformatf("v%0d_lsu_rdy", i), 32'(lsu_wb_ready), 32'(vt[i].e_lsu_rdy));
      chk($sformatf("v%0d_div_rdy", i), 32'(div_wb_ready), 32'(vt[i].e_div_rdy));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vt[i].e_en, vt[i].e_addr, vt[i].e_data, vt[i].e_stall);
    end

    // Starvation: ALU busy cycles 0..6, LSU loaded in cycle 0
    for (int c = 0; c < 10; c++) begin
      if (c < 7) drive(1'b1, 5'd11, 32'(c + 100), (c == 0), 5'd12, 32'h77, 1'b0, 5'd0, 32'd0);
      else       idle();
      #1;
      if (c >= 1 && c < 7) chk($sformatf("starve_c%0d_lsu_rdy", c), 32'(lsu_wb_ready), 32'd0);
      @(posedge clk);
      #1;
      // Outputs now show cycle c+1
      if (c < 7)
        chk_out($sformatf("starve_c%0d", c + 1), 1'b1, 5'd11, 32'(c + 100), (c >= 4));
      else if (c == 7)
        chk_out("starve_c8", 1'b1, 5'd12, 32'h77, 1'b1);
      else
        chk_out($sformatf("starve_c%0d", c + 1), 1'b0, 5'd12, 32'h77, 1'b0);
    end

    // Reset mid-operation with both buffers full
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h1313, 1'b1, 5'd14, 32'h1414);
    @(posedge clk);
    #1;
    idle();
    chk("mid_full_lsu_rdy", 32'(lsu_wb_ready), 32'd1);
    chk("mid_full_div_rdy", 32'(div_wb_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_lsu_rdy", 32'(lsu_wb_ready), 32'd1);
    chk("mid_rel_div_rdy", 32'(div_wb_ready), 32'd1);
`ifdef WB_INSTRET_EN
    chk("mid_rel_instret", instret_cnt[31:0], 32'd0);
`endif
    @(posedge clk);
    #1;
    chk_out("mid_rel_c1", 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_out("mid_rel_c2", 1'b0, 5'd0, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
